// File: rtl/ctrl_relu_ulaw.sv
// Sequencer for datapath_relu_ulaw: streams image and u-law weights, pulses MACs, skips zero args.
// All outputs are registered Moore outputs of the current state; no backpressure, start only honoured in IDLE/DONE.
module ctrl_relu_ulaw #(
   parameter int ADDR_WIDTH = 16,
   parameter int N_IN       = 785,
   parameter int N_H        = 25,
   parameter int N_OUT      = 10,
   parameter int IMG_BASE   = 0,
   parameter int W1_BASE    = 1024,
   parameter int W2_BASE    = 20736
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  arg_zero,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [2:0]            r_sh_en,
   output logic [1:0]            mac_en,
   output logic [1:0]            mac_clr,
   output logic [ADDR_WIDTH-1:0] l2_src_addr,
   output logic                  busy,
   output logic                  done
);

   localparam int KW   = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int JW   = $clog2(N_H + 1);
   localparam int CMAX = (N_H > N_OUT) ? N_H : N_OUT;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [KW-1:0]         K_LAST    = KW'(N_IN - 1);
   localparam logic [JW-1:0]         J_LAST    = JW'(N_H);
   localparam logic [CW-1:0]         C_W1_LAST = CW'(N_H);
   localparam logic [CW-1:0]         C_W2_LAST = CW'(N_OUT);
   localparam logic [ADDR_WIDTH-1:0] A_NH      = ADDR_WIDTH'(N_H);
   localparam logic [ADDR_WIDTH-1:0] A_NOUT    = ADDR_WIDTH'(N_OUT);
   localparam logic [ADDR_WIDTH-1:0] A_IMG     = ADDR_WIDTH'(IMG_BASE);
   localparam logic [ADDR_WIDTH-1:0] A_W1      = ADDR_WIDTH'(W1_BASE);
   localparam logic [ADDR_WIDTH-1:0] A_W2      = ADDR_WIDTH'(W2_BASE);
   localparam logic [ADDR_WIDTH-1:0] A_L2_NONE = ADDR_WIDTH'(N_H + 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_CLR   = 4'd1,
      S_A_RD  = 4'd2,
      S_A_LD  = 4'd3,
      S_A_CHK = 4'd4,
      S_W1    = 4'd5,
      S_MAC1  = 4'd6,
      S_W2    = 4'd7,
      S_MAC2  = 4'd8,
      S_DONE  = 4'd9
   } state_t;

   state_t                  state_q, state_d;
   logic [KW-1:0]           k_q, k_d;
   logic [JW-1:0]           j_q, j_d;
   logic [CW-1:0]           c_q, c_d;
   logic [ADDR_WIDTH-1:0]   wp_q, wp_d;
   logic                    next_arg;

   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [2:0]              r_sh_en_q, r_sh_en_d;
   logic [1:0]              mac_en_q, mac_en_d;
   logic [1:0]              mac_clr_q, mac_clr_d;
   logic [ADDR_WIDTH-1:0]   l2_src_addr_q, l2_src_addr_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         k_q           <= '0;
         j_q           <= '0;
         c_q           <= '0;
         wp_q          <= A_W1;
         mem_addr_q    <= '0;
         r_sh_en_q     <= '0;
         mac_en_q      <= '0;
         mac_clr_q     <= '0;
         l2_src_addr_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         j_q           <= j_d;
         c_q           <= c_d;
         wp_q          <= wp_d;
         mem_addr_q    <= mem_addr_d;
         r_sh_en_q     <= r_sh_en_d;
         mac_en_q      <= mac_en_d;
         mac_clr_q     <= mac_clr_d;
         l2_src_addr_q <= l2_src_addr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      j_d      = j_q;
      c_d      = c_q;
      wp_d     = wp_q;
      next_arg = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            k_d  = '0;
            j_d  = '0;
            c_d  = '0;
            wp_d = A_W1;
            if (start) begin
               state_d = S_CLR;
            end
         end
         S_CLR:  state_d = S_A_RD;
         S_A_RD: state_d = S_A_LD;
         S_A_LD: state_d = S_A_CHK;
         S_A_CHK: begin
            if (arg_zero) begin
               next_arg = 1'b1;
            end else begin
               c_d     = '0;
               state_d = S_W1;
            end
         end
         S_W1: begin
            if (c_q == C_W1_LAST) begin
               c_d     = '0;
               state_d = S_MAC1;
            end else begin
               c_d = c_q + 1'b1;
            end
         end
         S_MAC1: next_arg = 1'b1;
         S_W2: begin
            if (c_q == C_W2_LAST) begin
               c_d     = '0;
               state_d = S_MAC2;
            end else begin
               c_d = c_q + 1'b1;
            end
         end
         S_MAC2: begin
            wp_d = wp_q + A_NOUT;
            if (j_q == J_LAST) begin
               state_d = S_DONE;
            end else begin
               j_d     = j_q + 1'b1;
               c_d     = '0;
               state_d = S_W2;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Skipped and completed arguments share the advance to the next argument or to layer 2
      if (next_arg) begin
         if (k_q == K_LAST) begin
            j_d     = '0;
            c_d     = '0;
            wp_d    = A_W2;
            state_d = S_W2;
         end else begin
            k_d     = k_q + 1'b1;
            wp_d    = wp_q + A_NH;
            state_d = S_A_RD;
         end
      end
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q
   always_comb begin
      mem_addr_d    = mem_addr_q;
      r_sh_en_d     = '0;
      mac_en_d      = '0;
      mac_clr_d     = '0;
      l2_src_addr_d = A_L2_NONE;
      busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d        = (state_d == S_DONE);
      unique case (state_d)
         S_CLR:  mac_clr_d = 2'b11;
         S_A_RD: mem_addr_d = A_IMG + ADDR_WIDTH'(k_d);
         S_A_LD: r_sh_en_d[0] = 1'b1;
         S_W1: begin
            if (c_d < C_W1_LAST) begin
               mem_addr_d = wp_d + ADDR_WIDTH'(c_d);
            end
            r_sh_en_d[1] = (c_d != '0);
         end
         S_MAC1: mac_en_d[0] = 1'b1;
         S_W2: begin
            if (c_d < C_W2_LAST) begin
               mem_addr_d = wp_d + ADDR_WIDTH'(c_d);
            end
            r_sh_en_d[2] = (c_d != '0);
         end
         S_MAC2: begin
            mac_en_d[1]   = 1'b1;
            l2_src_addr_d = ADDR_WIDTH'(j_d);
         end
         default: ;
      endcase
   end

   assign mem_addr    = mem_addr_q;
   assign r_sh_en     = r_sh_en_q;
   assign mac_en      = mac_en_q;
   assign mac_clr     = mac_clr_q;
   assign l2_src_addr = l2_src_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_ctrl_relu_ulaw.sv
// Bench for ctrl_relu_ulaw: 1-cycle memory and R_ARG model, expected event stream queued per run.
module tb_ctrl_relu_ulaw;
   localparam int AW      = 16;
   localparam int N_IN    = 785;
   localparam int N_H     = 25;
   localparam int N_OUT   = 10;
   localparam int W1_BASE = 1024;
   localparam int W2_BASE = 20736;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          arg_zero;
   logic [AW-1:0] mem_addr;
   logic [2:0]    r_sh_en;
   logic [1:0]    mac_en;
   logic [1:0]    mac_clr;
   logic [AW-1:0] l2_src_addr;
   logic          busy;
   logic          done;

   ctrl_relu_ulaw dut (
      .clk(clk), .rst(rst), .start(start), .arg_zero(arg_zero),
      .mem_addr(mem_addr), .r_sh_en(r_sh_en), .mac_en(mac_en), .mac_clr(mac_clr),
      .l2_src_addr(l2_src_addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // kind: 0 R_ARG shift, 1 R1 shift, 2 R2 shift (val = address one cycle earlier), 3 MAC1, 4 MAC2 (val = l2_src_addr)
   typedef struct {
      int kind;
      int val;
   } ev_t;
   ev_t exp_q[$];

   int errors = 0;
   int checks = 0;
   logic [7:0] img [1024];
   logic [7:0] rdata;
   logic [7:0] rarg;
   bit   mon_en = 1'b0;
   int   busy_cnt, mac1_cnt, mac2_cnt, clr_cnt;
   logic prev_busy = 1'b0;
   logic [AW-1:0] prev_addr = '0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
      if (int'(a) < N_IN) return img[a[9:0]];
      return a[7:0] ^ 8'h5A;
   endfunction

   always @(posedge clk) begin
      rdata <= mem_rd(mem_addr);
      if (rst) rarg <= 8'h00;
      else if (r_sh_en[0]) rarg <= rdata;
   end
   assign arg_zero = (rarg == 8'hFF);

   task automatic got_ev(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_event_kind", kind, -1);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_val", val, e.val);
      end
   endtask

   // Monitor: every asserted enable pops one expectation
   always @(negedge clk) begin
      if (mon_en) begin
         for (int b = 0; b < 3; b++)
            if (r_sh_en[b]) got_ev(b, int'(prev_addr));
         if (mac_en[0]) begin got_ev(3, int'(l2_src_addr)); mac1_cnt++; end
         if (mac_en[1]) begin got_ev(4, int'(l2_src_addr)); mac2_cnt++; end
         if (busy) busy_cnt++;
         if (mac_clr == 2'b11) clr_cnt++;
         if (prev_busy && !busy) chk("done_after_busy", int'(done), 1);
      end
      prev_busy = busy;
      prev_addr = mem_addr;
   end

   // mode 0: bias 0x80, rest 0xFF; 1: all 0x10; 2: sparse (k%50==3 non-zero); 3: all 0xFF
   task automatic set_img(input int mode);
      for (int k = 0; k < 1024; k++) img[k] = 8'hFF;
      for (int k = 0; k < N_IN; k++) begin
         case (mode)
            0: img[k] = (k == 0) ? 8'h80 : 8'hFF;
            1: img[k] = 8'h10;
            2: img[k] = (k == 0) ? 8'h80 : ((k % 50 == 3) ? 8'h10 : 8'hFF);
            default: img[k] = 8'hFF;
         endcase
      end
   endtask

   task automatic push_run();
      exp_q.delete();
      for (int k = 0; k < N_IN; k++) begin
         exp_q.push_back('{kind: 0, val: k});
         if (img[k] != 8'hFF) begin
            for (int i = 0; i < N_H; i++) exp_q.push_back('{kind: 1, val: W1_BASE + k * N_H + i});
            exp_q.push_back('{kind: 3, val: N_H + 1});
         end
      end
      for (int j = 0; j <= N_H; j++) begin
         for (int i = 0; i < N_OUT; i++) exp_q.push_back('{kind: 2, val: W2_BASE + j * N_OUT + i});
         exp_q.push_back('{kind: 4, val: j});
      end
   endtask

   task automatic start_run();
      busy_cnt = 0; mac1_cnt = 0; mac2_cnt = 0; clr_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_mac_clr", int'(mac_clr), 3);
      chk("start_done_low", int'(done), 0);
   endtask

   task automatic wait_done(input int budget, input bit poke_w2);
      bit poked = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         if (poke_w2 && r_sh_en[2] && !poked) begin
            start = 1'b1;
            poked = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("done_reached", int'(done), 1);
   endtask

   task automatic end_checks(input int exp_busy, input int exp_mac1);
      chk("busy_cycles", busy_cnt, exp_busy);
      chk("mac1_pulses", mac1_cnt, exp_mac1);
      chk("mac2_pulses", mac2_cnt, N_H + 1);
      chk("clr_pulses", clr_cnt, 1);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_r_sh_en", int'(r_sh_en), 0);
      chk("rst_mac_en", int'(mac_en), 0);
      chk("rst_mac_clr", int'(mac_clr), 0);
      chk("rst_l2_src_addr", int'(l2_src_addr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
   endtask

   initial begin
      set_img(3);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Sparse image, start poked during W2 must be ignored: 1+3*768+17*30+26*12
      set_img(2); push_run(); start_run();
      wait_done(5000, 1'b1);
      end_checks(3127, 17);

      // Restart from DONE; bias only non-zero: 1+3*784+30+312
      set_img(0); push_run(); start_run();
      wait_done(4000, 1'b0);
      end_checks(2695, 1);

      // Fully non-zero image: 1+785*30+312
      set_img(1); push_run(); start_run();
      wait_done(30000, 1'b0);
      end_checks(23863, 785);

      // Bias itself 0xFF is skipped too: 1+3*785+312
      set_img(3); push_run(); start_run();
      wait_done(4000, 1'b0);
      end_checks(2668, 0);

      // Reset held for 3 cycles in the middle of W1 aborts the run
      set_img(2); push_run(); start_run();
      begin
         int n = 0;
         while (!r_sh_en[1] && n < 200) begin @(posedge clk); #1; n++; end
         chk("reached_w1", int'(r_sh_en[1]), 1);
      end
      repeat (5) begin @(posedge clk); #1; end
      mon_en = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      chk_reset_outputs();
      busy_cnt = 0; mac1_cnt = 0; mac2_cnt = 0; clr_cnt = 0;
      mon_en = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_mac_pulses", mac1_cnt + mac2_cnt, 0);
      chk("post_rst_busy", busy_cnt, 0);
      chk("post_rst_clr", clr_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
